// File: rtl/seq_adder_ctrl_if.sv
// seq_adder_ctrl_if: start/operand/result bundle for the sequential adder
interface seq_adder_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    modport master (output start, in1, in2, carry_in, input busy, done, sum, carry_out);
    modport slave (input start, in1, in2, carry_in, output busy, done, sum, carry_out);
endinterface

// File: rtl/seq_adder_ctrl.sv
// seq_adder_ctrl: sequential adder, one 2-bit structural full-adder slice per cycle
module full_adder_2b (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       ci,
    output logic [1:0] s,
    output logic       co
);
    logic c1;
    assign s[0] = a[0] ^ b[0] ^ ci;
    assign c1   = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
    assign s[1] = a[1] ^ b[1] ^ c1;
    assign co   = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
endmodule

module seq_adder_ctrl #(parameter int WIDTH = 8) (
    input logic           clk,
    input logic           rst,
    seq_adder_ctrl_if.slave bus
);
    localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic [1:0]       s;
    logic             co;
    full_adder_2b u_fa (
        .a  (a_q[{cnt, 1'b0} +: 2]),
        .b  (b_q[{cnt, 1'b0} +: 2]),
        .ci (carry_q),
        .s  (s),
        .co (co)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            carry_q       <= 1'b0;
            cnt           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.sum       <= '0;
            bus.carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_q      <= bus.in1;
                        b_q      <= bus.in2;
                        carry_q  <= bus.carry_in;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    bus.sum[{cnt, 1'b0} +: 2] <= s;
                    carry_q <= co;
                    cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
                    if (cnt == LAST) begin
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.carry_out <= co;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_adder_ctrl.sv
// tb_seq_adder_ctrl: directed and randomised checks of seq_adder_ctrl against an arithmetic model
module tb_seq_adder_ctrl;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    seq_adder_ctrl_if #(.WIDTH(W)) ifc();
    seq_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    endfunction

    // Drives one start pulse from an IDLE-cycle negedge, then scrambles the inputs;
    // returns the cycle done was seen in, busy cycles, result, and follow-up observations.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output int lat, output int bcnt, output logic [W-1:0] s,
                          output logic co, output logic tail_done, output logic co_held);
        logic co0;
        co0 = ifc.carry_out;
        co_held = 1'b1;
        ifc.in1 = a; ifc.in2 = b; ifc.carry_in = c; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0; ifc.in1 = ~a; ifc.in2 = W'($urandom); ifc.carry_in = ~c;
        lat = 1; bcnt = 0;
        while (!ifc.done && lat < 20) begin
            bcnt += int'(ifc.busy);
            if (ifc.carry_out !== co0) co_held = 1'b0;
            @(negedge clk);
            lat++;
        end
        s = ifc.sum; co = ifc.carry_out;
        @(negedge clk);
        tail_done = ifc.done;
    endtask

    task automatic test_reset;
        rst = 1'b1; ifc.start = 1'b0; ifc.in1 = '0; ifc.in2 = '0; ifc.carry_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", ifc.busy); end
        checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", ifc.done); end
        checks++; if (ifc.sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", ifc.sum); end
        checks++; if (ifc.carry_out !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", ifc.carry_out); end
        ifc.start = 1'b1; ifc.in1 = 8'h12; ifc.in2 = 8'h34;
        @(negedge clk);
        rst = 1'b0; ifc.start = 1'b0;
        @(negedge clk);
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL rst_over_start got busy %b want 0", ifc.busy); end
    endtask

    task automatic test_basic;
        logic [W-1:0] va [2] = '{8'h3C, 8'hFF};
        logic [W-1:0] vb [2] = '{8'h5A, 8'h00};
        logic         vc [2] = '{1'b0, 1'b1};
        logic [W-1:0] es [2] = '{8'h96, 8'h00};
        logic         ec [2] = '{1'b0, 1'b1};
        int lat, bcnt;
        logic [W-1:0] s;
        logic co, td, ch;
        for (int i = 0; i < 2; i++) begin
            run_op(va[i], vb[i], vc[i], lat, bcnt, s, co, td, ch);
            checks++; if (lat !== 5) begin errors++; $display("FAIL basic%0d_latency got %0d want 5", i, lat); end
            checks++; if (bcnt !== 4) begin errors++; $display("FAIL basic%0d_busy_cycles got %0d want 4", i, bcnt); end
            checks++; if (s !== es[i]) begin errors++; $display("FAIL basic%0d_sum got %h want %h", i, s, es[i]); end
            checks++; if (co !== ec[i]) begin errors++; $display("FAIL basic%0d_cout got %b want %b", i, co, ec[i]); end
            checks++; if (td !== 1'b0) begin errors++; $display("FAIL basic%0d_done_pulse got %b want 0", i, td); end
        end
    endtask

    task automatic test_back_to_back;
        int t, gap;
        ifc.in1 = 8'hFF; ifc.in2 = 8'hFF; ifc.carry_in = 1'b1; ifc.start = 1'b1;
        @(negedge clk);
        ifc.in1 = 8'h01; ifc.in2 = 8'h01; ifc.carry_in = 1'b0;
        t = 1;
        while (!ifc.done && t < 20) begin @(negedge clk); t++; end
        checks++; if (t !== 5) begin errors++; $display("FAIL b2b_first_latency got %0d want 5", t); end
        checks++; if (ifc.sum !== 8'hFF) begin errors++; $display("FAIL b2b_first_sum got %h want ff", ifc.sum); end
        checks++; if (ifc.carry_out !== 1'b1) begin errors++; $display("FAIL b2b_first_cout got %b want 1", ifc.carry_out); end
        @(negedge clk);
        gap = 1;
        while (!ifc.done && gap < 20) begin @(negedge clk); gap++; end
        ifc.start = 1'b0;
        checks++; if (gap !== 6) begin errors++; $display("FAIL b2b_period got %0d want 6", gap); end
        checks++; if (ifc.sum !== 8'h02) begin errors++; $display("FAIL b2b_second_sum got %h want 02", ifc.sum); end
        checks++; if (ifc.carry_out !== 1'b0) begin errors++; $display("FAIL b2b_second_cout got %b want 0", ifc.carry_out); end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int lat, dn, bz;
        ifc.in1 = 8'h47; ifc.in2 = 8'h2E; ifc.carry_in = 1'b1; ifc.start = 1'b1;
        @(negedge clk);
        lat = 1;
        while (!ifc.done && lat < 20) begin
            ifc.in1 = W'($urandom); ifc.in2 = W'($urandom); ifc.carry_in = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        ifc.start = 1'b0;
        checks++; if (lat !== 5) begin errors++; $display("FAIL ignore_latency got %0d want 5", lat); end
        checks++; if (ifc.sum !== 8'h76) begin errors++; $display("FAIL ignore_sum got %h want 76", ifc.sum); end
        checks++; if (ifc.carry_out !== 1'b0) begin errors++; $display("FAIL ignore_cout got %b want 0", ifc.carry_out); end
        dn = 0; bz = 0;
        repeat (8) begin @(negedge clk); dn += int'(ifc.done); bz += int'(ifc.busy); end
        checks++; if (dn !== 0 || bz !== 0) begin errors++; $display("FAIL ignore_quiet got done %0d busy %0d want 0 0", dn, bz); end
    endtask

    task automatic test_mid_reset;
        int lat, bcnt, dn;
        logic [W-1:0] s;
        logic co, td, ch;
        logic [W:0] e;
        ifc.in1 = 8'hC3; ifc.in2 = 8'h9D; ifc.carry_in = 1'b1; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({ifc.busy, ifc.done} !== 2'b00) begin errors++; $display("FAIL midrst_flags got %b%b want 00", ifc.busy, ifc.done); end
        checks++; if (ifc.sum !== 8'h00) begin errors++; $display("FAIL midrst_sum got %h want 00", ifc.sum); end
        checks++; if (ifc.carry_out !== 1'b0) begin errors++; $display("FAIL midrst_cout got %b want 0", ifc.carry_out); end
        dn = 0;
        repeat (8) begin @(negedge clk); dn += int'(ifc.done); end
        checks++; if (dn !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dn); end
        e = ref_add(8'hB7, 8'hE9, 1'b0);
        run_op(8'hB7, 8'hE9, 1'b0, lat, bcnt, s, co, td, ch);
        checks++; if (lat !== 5) begin errors++; $display("FAIL postrst_latency got %0d want 5", lat); end
        checks++; if ({co, s} !== e) begin errors++; $display("FAIL postrst_result got %b_%h want %b_%h", co, s, e[W], e[W-1:0]); end
        ifc.in1 = 8'hFF; ifc.in2 = 8'h01; ifc.carry_in = 1'b0; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        lat = 1;
        while (!ifc.done && lat < 20) begin @(negedge clk); lat++; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({ifc.done, ifc.carry_out, ifc.sum} !== 10'h000) begin errors++; $display("FAIL donerst got done %b cout %b sum %h want 0 0 00", ifc.done, ifc.carry_out, ifc.sum); end
        @(negedge clk);
    endtask

    task automatic test_random;
        int lat, bcnt;
        logic [W-1:0] a, b, s;
        logic c, co, td, ch;
        logic [W:0] e;
        for (int n = 0; n < 1000; n++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            e = ref_add(a, b, c);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(a, b, c, lat, bcnt, s, co, td, ch);
            checks++; if ({co, s} !== e) begin errors++; $display("FAIL rand%0d_result %h+%h+%b got %b_%h want %b_%h", n, a, b, c, co, s, e[W], e[W-1:0]); end
            checks++; if (lat !== 5 || bcnt !== 4) begin errors++; $display("FAIL rand%0d_timing got lat %0d busy %0d want 5 4", n, lat, bcnt); end
            checks++; if (td !== 1'b0) begin errors++; $display("FAIL rand%0d_done_pulse got %b want 0", n, td); end
            checks++; if (ch !== 1'b1) begin errors++; $display("FAIL rand%0d_cout_stable got %b want 1", n, ch); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
